// File: rtl/spu_preload_pkg.sv
// -----------------------------------------------------------------------------
// spu_preload_pkg
// Shared definitions for the SPU preload sequencer: target encodings, command
// opcodes, error codes, header field positions and the sequencer state enum.
// Header words use MSB-first numbering on the wire (bit 0 = MSB). The field
// positions below are the matching descending-vector positions, so
// header[0:1] maps to s_data[31:30].
// Optional feature macro: PRELOAD_CHECKSUM_EN (adds the CHKWAIT state).
// -----------------------------------------------------------------------------
package spu_preload_pkg;

    typedef enum logic [1:0] {
        TGT_IMEM = 2'b00,
        TGT_RF   = 2'b01,
        TGT_LS   = 2'b10,
        TGT_CMD  = 2'b11
    } tgt_e;

    localparam logic [15:0] CMD_RUN   = 16'd0;
    localparam logic [15:0] CMD_HALT  = 16'd1;
    localparam logic [15:0] CMD_CHECK = 16'd2;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_ZERO_LEN = 2'd1,
        ERR_RUNNING  = 2'd2,
        ERR_BAD_CMD  = 2'd3
    } err_e;

    // Header fields: target [0:1], base/opcode [2:17], length [18:31].
    localparam int HDR_TGT_LO  = 30;
    localparam int HDR_TGT_W   = 2;
    localparam int HDR_BASE_LO = 14;
    localparam int HDR_BASE_W  = 16;
    localparam int HDR_LEN_LO  = 0;

    typedef enum logic [1:0] {
        HDR,
        PAYLOAD,
        ERR
`ifdef PRELOAD_CHECKSUM_EN
        , CHKWAIT
`endif
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spu_preload_sequencer_if.sv
// -----------------------------------------------------------------------------
// spu_preload_sequencer_if
// Bundles the loader stream, error clear, the three preload write ports and
// the core control/status outputs of the preload sequencer.
//   slave  : sequencer view (consumes the stream, drives writes and status)
//   master : host/loader view
// Signals: s_valid/s_ready/s_data (stream), clr_err, imem_* / rf_* / ls_*
// write ports, core_rst, busy, err_code, and csum when PRELOAD_CHECKSUM_EN.
// -----------------------------------------------------------------------------
interface spu_preload_sequencer_if #(
    parameter int IN_W    = 32,
    parameter int WIDE_W  = 128,
    parameter int IMEM_AW = 10,
    parameter int RF_AW   = 7,
    parameter int LS_AW   = 11
);
    logic                s_valid;
    logic                s_ready;
    logic [IN_W-1:0]     s_data;
    logic                clr_err;

    logic                imem_we;
    logic [IMEM_AW-1:0]  imem_addr;
    logic [IN_W-1:0]     imem_data;
    logic                rf_we;
    logic [RF_AW-1:0]    rf_addr;
    logic [WIDE_W-1:0]   rf_data;
    logic                ls_we;
    logic [LS_AW-1:0]    ls_addr;
    logic [WIDE_W-1:0]   ls_data;

    logic                core_rst;
    logic                busy;
    logic [1:0]          err_code;
`ifdef PRELOAD_CHECKSUM_EN
    logic [IN_W-1:0]     csum;
`endif

    modport slave (
        input  s_valid, s_data, clr_err,
        output s_ready,
        output imem_we, imem_addr, imem_data,
        output rf_we, rf_addr, rf_data,
        output ls_we, ls_addr, ls_data,
        output core_rst, busy, err_code
`ifdef PRELOAD_CHECKSUM_EN
        , output csum
`endif
    );

    modport master (
        output s_valid, s_data, clr_err,
        input  s_ready,
        input  imem_we, imem_addr, imem_data,
        input  rf_we, rf_addr, rf_data,
        input  ls_we, ls_addr, ls_data,
        input  core_rst, busy, err_code
`ifdef PRELOAD_CHECKSUM_EN
        , input csum
`endif
    );

endinterface

// File: rtl/spu_beat_packer.sv
// -----------------------------------------------------------------------------
// spu_beat_packer
// Packs IN_W-bit stream words into WIDE_W-bit beats, first word in the most
// significant slot. The beat size is chosen at run time: one word (wide=0)
// or WIDE_W/IN_W words (wide=1).
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   clear        : drop any partial beat (held while no burst is active)
//   wide         : 1 = WIDE_W/IN_W words per beat, 0 = one word per beat
//   in_valid     : a payload word is accepted this cycle
//   in_data      : the accepted word
//   beat_done    : combinational strobe, this word completes a beat
//   beat_data    : the completed beat, valid while beat_done is high
//                  (single-word beats sit in the low IN_W bits)
// -----------------------------------------------------------------------------
module spu_beat_packer #(
    parameter int IN_W   = 32,
    parameter int WIDE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wide,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_data,
    output logic              beat_done,
    output logic [WIDE_W-1:0] beat_data
);
    localparam int RATIO = WIDE_W / IN_W;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [CNT_W-1:0]  cnt_q;
    logic [WIDE_W-1:0] shreg_q;
    logic              last_word;

    assign last_word = wide ? (cnt_q == CNT_W'(RATIO - 1)) : 1'b1;
    assign beat_done = in_valid && last_word;
    // Older words move toward the MSB as each new word enters at the bottom.
    assign beat_data = (shreg_q << IN_W) | WIDE_W'(in_data);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            cnt_q <= '0;
        end else if (in_valid) begin
            cnt_q <= beat_done ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: the shift register is pure datapath and carries no reset; stale
    // contents are shifted out before any beat built from them is consumed.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            shreg_q <= beat_data;
        end
    end

endmodule

// File: rtl/spu_preload_sequencer.sv
// -----------------------------------------------------------------------------
// spu_preload_sequencer
// Turns a framed valid/ready word stream (header + payload) into burst writes
// to the SPU instruction memory, register file or local store, and controls
// the core reset through RUN/HALT commands.
// Ports:
//   clk  : clock
//   rst  : synchronous active-low reset
//   bus  : spu_preload_sequencer_if.slave
//          s_valid/s_ready/s_data stream in, clr_err,
//          imem/rf/ls write ports, core_rst, busy, err_code (+ csum)
// Optional feature macro: PRELOAD_CHECKSUM_EN
//   Adds an XOR accumulator of payload words (csum output) and the CHECK
//   command, which compares the accumulator with the next stream word.
// -----------------------------------------------------------------------------
module spu_preload_sequencer
    import spu_preload_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int WIDE_W  = 128,
    parameter int IMEM_AW = 10,
    parameter int RF_AW   = 7,
    parameter int LS_AW   = 11,
    parameter int LEN_W   = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    spu_preload_sequencer_if.slave  bus
);
    // One address counter serves all targets; each port takes its low bits,
    // which gives the modulo-2^AW wrap for free.
    localparam int ADDR_W = max3(IMEM_AW, RF_AW, LS_AW);

    state_e             state_q, state_d;
    err_e               err_q, err_d;
    logic               core_rst_q, core_rst_d;
    tgt_e               tgt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   beats_q;
    logic               load_hdr;

    logic               imem_we_q, rf_we_q, ls_we_q;
    logic [IMEM_AW-1:0] imem_addr_q;
    logic [IN_W-1:0]    imem_data_q;
    logic [RF_AW-1:0]   rf_addr_q;
    logic [WIDE_W-1:0]  rf_data_q;
    logic [LS_AW-1:0]   ls_addr_q;
    logic [WIDE_W-1:0]  ls_data_q;

    logic               accept;
    logic               payload_word;
    logic               beat_done;
    logic [WIDE_W-1:0]  beat_data;
    logic               beat_fire;

    tgt_e               hdr_tgt;
    logic [15:0]        hdr_op;
    logic [ADDR_W-1:0]  hdr_base;
    logic [LEN_W-1:0]   hdr_len;

`ifdef PRELOAD_CHECKSUM_EN
    logic [IN_W-1:0]    csum_q;
    logic               csum_clr;
`endif

    assign hdr_tgt  = tgt_e'(bus.s_data[HDR_TGT_LO +: HDR_TGT_W]);
    assign hdr_op   = bus.s_data[HDR_BASE_LO +: HDR_BASE_W];
    assign hdr_base = bus.s_data[HDR_BASE_LO +: ADDR_W];
    assign hdr_len  = bus.s_data[HDR_LEN_LO +: LEN_W];

    // Ready is forced low during the reset cycle itself, not just after it.
    assign bus.s_ready   = rst && (state_q != ERR);
    assign accept        = bus.s_valid && bus.s_ready;
    assign payload_word  = accept && (state_q == PAYLOAD);
    assign beat_fire     = payload_word && beat_done;

    spu_beat_packer #(
        .IN_W   (IN_W),
        .WIDE_W (WIDE_W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_q != PAYLOAD),
        .wide      (tgt_q != TGT_IMEM),
        .in_valid  (payload_word),
        .in_data   (bus.s_data),
        .beat_done (beat_done),
        .beat_data (beat_data)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        core_rst_d = core_rst_q;
        load_hdr   = 1'b0;
`ifdef PRELOAD_CHECKSUM_EN
        csum_clr   = 1'b0;
`endif
        case (state_q)
            HDR: begin
                if (accept) begin
                    if (hdr_tgt == TGT_CMD) begin
                        // The length field is ignored for commands.
                        if (hdr_op == CMD_RUN) begin
                            core_rst_d = 1'b0;
`ifdef PRELOAD_CHECKSUM_EN
                            csum_clr   = 1'b1;
`endif
                        end else if (hdr_op == CMD_HALT) begin
                            core_rst_d = 1'b1;
`ifdef PRELOAD_CHECKSUM_EN
                        end else if (hdr_op == CMD_CHECK) begin
                            state_d = CHKWAIT;
`endif
                        end else begin
                            state_d = ERR;
                            err_d   = ERR_BAD_CMD;
                        end
                    end else if (hdr_len == '0) begin
                        state_d = ERR;
                        err_d   = ERR_ZERO_LEN;
                    end else if (!core_rst_q) begin
                        // Writing memories under a running core is refused.
                        state_d = ERR;
                        err_d   = ERR_RUNNING;
                    end else begin
                        load_hdr = 1'b1;
                        state_d  = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                // Leaving on the last beat lets the next header be accepted
                // in the same cycle as the final write pulse.
                if (beat_fire && beats_q == LEN_W'(1)) begin
                    state_d = HDR;
                end
            end
            ERR: begin
                if (bus.clr_err) begin
                    state_d = HDR;
                    err_d   = ERR_NONE;
                end
            end
`ifdef PRELOAD_CHECKSUM_EN
            CHKWAIT: begin
                if (accept) begin
                    if (bus.s_data == csum_q) begin
                        state_d = HDR;
                    end else begin
                        state_d = ERR;
                        err_d   = ERR_BAD_CMD;
                    end
                end
            end
`endif
            default: begin
                state_d = HDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= HDR;
            err_q       <= ERR_NONE;
            core_rst_q  <= 1'b1;
            tgt_q       <= TGT_IMEM;
            addr_q      <= '0;
            beats_q     <= '0;
            imem_we_q   <= 1'b0;
            rf_we_q     <= 1'b0;
            ls_we_q     <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            rf_addr_q   <= '0;
            rf_data_q   <= '0;
            ls_addr_q   <= '0;
            ls_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            core_rst_q <= core_rst_d;
            imem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            ls_we_q    <= 1'b0;

            if (load_hdr) begin
                tgt_q   <= hdr_tgt;
                addr_q  <= hdr_base;
                beats_q <= hdr_len;
            end

            if (beat_fire) begin
                addr_q  <= addr_q + 1'b1;
                beats_q <= beats_q - 1'b1;
                case (tgt_q)
                    TGT_IMEM: begin
                        imem_we_q   <= 1'b1;
                        imem_addr_q <= addr_q[IMEM_AW-1:0];
                        imem_data_q <= beat_data[IN_W-1:0];
                    end
                    TGT_RF: begin
                        rf_we_q   <= 1'b1;
                        rf_addr_q <= addr_q[RF_AW-1:0];
                        rf_data_q <= beat_data;
                    end
                    TGT_LS: begin
                        ls_we_q   <= 1'b1;
                        ls_addr_q <= addr_q[LS_AW-1:0];
                        ls_data_q <= beat_data;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef PRELOAD_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst || csum_clr) begin
            csum_q <= '0;
        end else if (payload_word) begin
            csum_q <= csum_q ^ bus.s_data;
        end
    end

    assign bus.csum = csum_q;
`endif

    assign bus.imem_we   = imem_we_q;
    assign bus.imem_addr = imem_addr_q;
    assign bus.imem_data = imem_data_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_addr   = rf_addr_q;
    assign bus.rf_data   = rf_data_q;
    assign bus.ls_we     = ls_we_q;
    assign bus.ls_addr   = ls_addr_q;
    assign bus.ls_data   = ls_data_q;
    assign bus.core_rst  = core_rst_q;
    assign bus.busy      = (state_q == PAYLOAD);
    assign bus.err_code  = err_q;

endmodule

// File: doc/spu_preload_sequencer.md
Name: spu_preload_sequencer

Overview:
- Hardware replacement for bench-driven preloading of the SPU.
- Accepts one valid/ready stream of 32-bit words carrying framed bursts: header followed by payload.
- Each burst writes one of three targets: instruction memory (imem), register file (rf) or local store (ls). Core reset is held until a RUN command arrives.
- Sits between the host/loader interface and top_level's load/preload ports. Generalises the single-word, per-target preload strobes into parametrised burst writes with auto-increment, beat packing and error handling.

Parameters:
- IN_W, 32, stream word width; also the imem word width.
- WIDE_W, 128, rf/ls beat width; must be a multiple of IN_W.
- IMEM_AW, 10, imem address width.
- RF_AW, 7, rf address width.
- LS_AW, 11, ls address width (128-bit beat index).
- LEN_W, 14, burst length field width.

Ports:
- clk, in, 1, single clock.
- rst, in, 1, synchronous, active-low reset.
- s_valid, in, 1, stream word valid.
- s_ready, out, 1, stream word accepted when s_valid&&s_ready.
- s_data, in, IN_W, stream word, bit 0 = MSB.
- clr_err, in, 1, pulse; leaves ERR state and clears err_code.
- imem_we / imem_addr / imem_data, out, 1 / IMEM_AW / IN_W, imem write.
- rf_we / rf_addr / rf_data, out, 1 / RF_AW / WIDE_W, rf write.
- ls_we / ls_addr / ls_data, out, 1 / LS_AW / WIDE_W, ls write.
- core_rst, out, 1, active-high reset to top_level; 1 = core held.
- busy, out, 1, 1 when a burst is in progress (PAYLOAD state).
- err_code, out, 2, 0 none, 1 zero length, 2 write while running, 3 bad command.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=HDR, all *_we=0, addr/data outputs=0.
  - core_rst=1, err_code=0, s_ready=0 during the reset cycle.
- Header word fields:
  - [0:1] target: 00 imem, 01 rf, 10 ls, 11 cmd.
  - [2:17] base address; only the low *_AW bits are used.
  - [18:31] length in beats (LEN_W).
- Beat size: words per beat K = 1 for imem, WIDE_W/IN_W (4) for rf and ls.
- Packing: the first word of a beat goes to bits [0:IN_W-1].
- States:
  - HDR: s_ready=1. On accept:
    - length==0 -> ERR, err_code=1.
    - data target while core_rst==0 -> ERR, err_code=2.
    - data target otherwise -> latch target/base/length, go to PAYLOAD.
    - cmd target: opcode = header[2:17]. 0 RUN -> core_rst=0 next cycle. 1 HALT -> core_rst=1 next cycle. Other -> ERR, err_code=3. Length field ignored for cmd.
  - PAYLOAD: s_ready=1.
    - Words are packed into a beat.
    - When word K-1 of a beat is accepted, the target's *_we pulses for exactly 1 cycle on the next cycle, with addr = current address and the completed data.
    - The address then increments modulo 2^AW; wrap-around is silent.
    - After the last beat, return to HDR in the same cycle as the write pulse.
    - Back-to-back words give back-to-back beats; s_valid gaps pause packing with no timeout.
  - ERR: s_ready=0, no writes, core_rst unchanged. clr_err -> HDR, err_code=0.
- busy=1 only in PAYLOAD.
- At most one *_we is high in any cycle.
- Reset mid-burst discards the partial beat; no write is issued.
- clr_err outside ERR is ignored.
- A header accepted in the same cycle as the final write pulse is legal; there is no bubble.

Optional Feature:
- Macro PRELOAD_CHECKSUM_EN.
- With the macro:
  - A 32-bit XOR accumulator of every accepted payload word, cleared by reset and by RUN.
  - Cmd opcode 2 CHECK: the next accepted word is the expected value. Mismatch -> ERR, err_code=3. Match -> HDR.
  - Extra output port csum (out, IN_W) exposes the accumulator.
- Without the macro: opcode 2 is a bad command (err_code=3) and there is no csum port.

Decomposition:
- Package spu_preload_pkg holds:
  - target encodings (TGT_IMEM, TGT_RF, TGT_LS, TGT_CMD);
  - command opcodes (CMD_RUN, CMD_HALT, CMD_CHECK);
  - err_code values;
  - header field bit positions;
  - the state enum (HDR, PAYLOAD, ERR, plus CHKWAIT under the macro).
- Sub-module spu_beat_packer:
  - parametrised by IN_W and WIDE_W;
  - per-beat word counter and shift register;
  - beat_done strobe;
  - runtime K select (1 or WIDE_W/IN_W).

Test Plan:
- imem burst: header 00,base 0x000,len 3 then words 0x11111111, 0x22222222, 0x33333333 -> imem_we pulses at addr 0,1,2 with those data; busy falls after the third pulse.
- ls burst: header 10,base 0x010,len 2 then 8 words 1..8 -> ls_we at 0x010 with 0x00000001_00000002_00000003_00000004, then at 0x011 with 0x00000005_00000006_00000007_00000008.
- Wrap: rf header base 0x7F, len 2, 8 words -> rf_we at addr 0x7F, then at 0x00.
- Run/halt: RUN cmd -> core_rst falls the next cycle; an imem header then -> err_code=2, s_ready=0; clr_err -> HDR; HALT cmd -> core_rst=1.
- Zero length and backpressure: header len 0 -> err_code=1; random s_valid gaps in a 4-beat ls burst produce the same writes as the gapless case.
- Reset mid-burst: rst low after 2 of 4 ls words -> no ls_we; core_rst=1, state HDR. With PRELOAD_CHECKSUM_EN: CHECK with the correct XOR -> no error, with a wrong value -> err_code=3.
